// File: rtl/ac_pkg.sv
// Shared types and default constants for the air-conditioner climate scheduler.
// State encodings match the state_o debug output seen by the board.
package ac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COOL  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } ac_state_t;

    localparam int AC_TEMP_BITS     = 3;
    localparam int AC_TICK_DIV      = 4;
    localparam int AC_MIN_OFF_TICKS = 3;
    localparam int AC_DRIP_LIMIT    = 10;

endpackage

// File: rtl/ac_tick_gen.sv
// Free-running step-tick generator: tick is high for the one cycle where the
// counter sits at TICK_DIV-1, after which the counter wraps to 0.
module ac_tick_gen
    import ac_pkg::*;
#(
    parameter int TICK_DIV = AC_TICK_DIV
) (
    input  logic clk_2,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/ac_climate_scheduler.sv
// Setpoint handling and cool/heat/hold/drain sequencing for the AC datapath.
// Optional drain-timeout fault flag is enabled by defining AC_DRIP_TIMEOUT_EN.
module ac_climate_scheduler
    import ac_pkg::*;
#(
    parameter int TEMP_BITS     = AC_TEMP_BITS,
    parameter int TICK_DIV      = AC_TICK_DIV,
    parameter int MIN_OFF_TICKS = AC_MIN_OFF_TICKS,
    parameter int DRIP_LIMIT    = AC_DRIP_LIMIT
`ifdef AC_DRIP_TIMEOUT_EN
    ,
    parameter int DRIP_TIMEOUT_TICKS = 8
`endif
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 drip_ack,
    output logic [TEMP_BITS-1:0] desired,
    output logic [TEMP_BITS-1:0] actual,
    output logic                 cool_on,
    output logic                 heat_on,
    output logic                 drip_req,
`ifdef AC_DRIP_TIMEOUT_EN
    output logic                 drip_fault,
`endif
    output logic [2:0]           state_o
);

    localparam int HW = $clog2(MIN_OFF_TICKS + 1);
    localparam int CW = $clog2(DRIP_LIMIT + 1);
    localparam logic [TEMP_BITS-1:0] T_MAX    = {TEMP_BITS{1'b1}};
    localparam logic [HW-1:0]        HOLD_LD  = HW'(MIN_OFF_TICKS);
    localparam logic [HW-1:0]        HOLD_END = HW'(1);
    localparam logic [CW-1:0]        DRIP_MAX = CW'(DRIP_LIMIT);

    logic tick;

    ac_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_2 (clk_2),
        .reset (reset),
        .tick  (tick)
    );

    ac_state_t            state, state_n;
    logic [TEMP_BITS-1:0] actual_n;
    logic [HW-1:0]        hold_cnt, hold_n;
    logic [CW-1:0]        cool_cnt, cool_cnt_n;
    logic                 up_q, down_q;
    logic                 up_rise, down_rise;

    assign up_rise   = btn_up & ~up_q;
    assign down_rise = btn_down & ~down_q;
    assign state_o   = state;

    // Setpoint follows button rises in every state; simultaneous rises cancel.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            desired <= '0;
        end else begin
            up_q   <= btn_up;
            down_q <= btn_down;
            if (up_rise && !down_rise && desired != T_MAX) begin
                desired <= desired + 1'b1;
            end else if (down_rise && !up_rise && desired != '0) begin
                desired <= desired - 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        actual_n   = actual;
        hold_n     = hold_cnt;
        cool_cnt_n = cool_cnt;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    if (desired > actual) begin
                        state_n = ST_HEAT;
                    end else if (desired < actual) begin
                        state_n = ST_COOL;
                    end
                end
            end
            ST_COOL: begin
                if (tick) begin
                    if (desired >= actual) begin
                        state_n = ST_HOLD;
                    end else begin
                        actual_n   = actual - 1'b1;
                        cool_cnt_n = cool_cnt + 1'b1;
                        // Drain service outranks the normal settle into HOLD.
                        if (cool_cnt_n == DRIP_MAX) begin
                            state_n = ST_DRAIN;
                        end else if (actual_n == desired) begin
                            state_n = ST_HOLD;
                        end
                    end
                end
            end
            ST_HEAT: begin
                if (tick) begin
                    if (desired <= actual) begin
                        state_n = ST_HOLD;
                    end else begin
                        actual_n = actual + 1'b1;
                        if (actual_n == desired) begin
                            state_n = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (hold_cnt <= HOLD_END) begin
                        state_n = ST_IDLE;
                    end else begin
                        hold_n = hold_cnt - 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drip_ack) begin
                    cool_cnt_n = '0;
                    state_n    = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (state_n == ST_HOLD && state != ST_HOLD) begin
            hold_n = HOLD_LD;
        end
    end

    // Actuator and request outputs are registered from the next state (Moore).
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state    <= ST_IDLE;
            actual   <= '0;
            hold_cnt <= '0;
            cool_cnt <= '0;
            cool_on  <= 1'b0;
            heat_on  <= 1'b0;
            drip_req <= 1'b0;
        end else begin
            state    <= state_n;
            actual   <= actual_n;
            hold_cnt <= hold_n;
            cool_cnt <= cool_cnt_n;
            cool_on  <= (state_n == ST_COOL);
            heat_on  <= (state_n == ST_HEAT);
            drip_req <= (state_n == ST_DRAIN);
        end
    end

`ifdef AC_DRIP_TIMEOUT_EN
    localparam int TW = $clog2(DRIP_TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(DRIP_TIMEOUT_TICKS);

    logic [TW-1:0] drain_ticks;
    logic [TW-1:0] drain_ticks_inc;

    assign drain_ticks_inc = drain_ticks + 1'b1;

    // Fault is sticky; the FSM keeps waiting in DRAIN for the ack regardless.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            drain_ticks <= '0;
            drip_fault  <= 1'b0;
        end else if (state != ST_DRAIN) begin
            drain_ticks <= '0;
        end else if (tick && drain_ticks != T_LIMIT) begin
            drain_ticks <= drain_ticks_inc;
            if (drain_ticks_inc == T_LIMIT) begin
                drip_fault <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ac_climate_scheduler.sv
// Self-checking bench for ac_climate_scheduler: setpoint table, directed
// heat/cool/drain sequences, then randomized buttons/acks against a model.
module tb_ac_climate_scheduler;

    localparam int P_TB  = 3;
    localparam int P_TD  = 2;
    localparam int P_MO  = 2;
    localparam int P_DL  = 3;
    localparam int P_TO  = 4;
    localparam int T_MAX = (1 << P_TB) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_COOL  = 1;
    localparam int S_HEAT  = 2;
    localparam int S_HOLD  = 3;
    localparam int S_DRAIN = 4;

    logic            clk_2 = 1'b0;
    logic            reset = 1'b1;
    logic            btn_up = 1'b0;
    logic            btn_down = 1'b0;
    logic            drip_ack = 1'b0;
    logic [P_TB-1:0] desired;
    logic [P_TB-1:0] actual;
    logic            cool_on;
    logic            heat_on;
    logic            drip_req;
    logic [2:0]      state_o;
`ifdef AC_DRIP_TIMEOUT_EN
    logic            drip_fault;
`endif

    ac_climate_scheduler #(
        .TEMP_BITS     (P_TB),
        .TICK_DIV      (P_TD),
        .MIN_OFF_TICKS (P_MO),
        .DRIP_LIMIT    (P_DL)
`ifdef AC_DRIP_TIMEOUT_EN
        ,
        .DRIP_TIMEOUT_TICKS (P_TO)
`endif
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .drip_ack (drip_ack),
        .desired  (desired),
        .actual   (actual),
        .cool_on  (cool_on),
        .heat_on  (heat_on),
        .drip_req (drip_req),
`ifdef AC_DRIP_TIMEOUT_EN
        .drip_fault (drip_fault),
`endif
        .state_o  (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_2 = ~clk_2;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [P_TB-1:0] exp_q[$];
    int last_act;
    bit last_drive;

    // ---------------- reference model ----------------
    int m_des, m_act, m_cc, m_hold, m_cnt, m_state, m_dt;
    bit m_pu, m_pd, m_fault;

    typedef struct {
        bit up;
        bit dn;
        int exp_des;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit u, bit d, int e);
        vec_t v;
        v.up = u;
        v.dn = d;
        v.exp_des = e;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit up, input bit dn, input bit ack);
        bit tick, ur, dr;
        int prev;
        if (rst) begin
            m_des = 0; m_act = 0; m_cc = 0; m_hold = 0; m_cnt = 0;
            m_state = S_IDLE; m_dt = 0; m_pu = 0; m_pd = 0; m_fault = 0;
            return;
        end
        tick  = (m_cnt == P_TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        ur    = up && !m_pu;
        dr    = dn && !m_pd;
        prev  = m_state;
        if (prev != S_DRAIN) begin
            m_dt = 0;
        end else if (tick && m_dt < P_TO) begin
            m_dt++;
            if (m_dt == P_TO) m_fault = 1;
        end
        case (prev)
            S_IDLE: if (tick) begin
                if (m_des > m_act) m_state = S_HEAT;
                else if (m_des < m_act) m_state = S_COOL;
            end
            S_COOL: if (tick) begin
                if (m_act <= m_des) m_state = S_HOLD;
                else begin
                    m_act--;
                    m_cc++;
                    if (m_cc == P_DL) m_state = S_DRAIN;
                    else if (m_act == m_des) m_state = S_HOLD;
                end
            end
            S_HEAT: if (tick) begin
                if (m_act >= m_des) m_state = S_HOLD;
                else begin
                    m_act++;
                    if (m_act == m_des) m_state = S_HOLD;
                end
            end
            S_HOLD: if (tick) begin
                if (m_hold == 1) m_state = S_IDLE;
                else m_hold--;
            end
            S_DRAIN: if (ack) begin
                m_cc = 0;
                m_state = S_HOLD;
            end
            default: ;
        endcase
        if (m_state == S_HOLD && prev != S_HOLD) m_hold = P_MO;
        if (ur && !dr && m_des < T_MAX) m_des++;
        else if (dr && !ur && m_des > 0) m_des--;
        m_pu = up;
        m_pd = dn;
    endtask

    task automatic check_all();
        check("desired", int'(desired), m_des);
        check("actual", int'(actual), m_act);
        check("cool_on", int'(cool_on), int'(m_state == S_COOL));
        check("heat_on", int'(heat_on), int'(m_state == S_HEAT));
        check("drip_req", int'(drip_req), int'(m_state == S_DRAIN));
        check("state_o", int'(state_o), m_state);
`ifdef AC_DRIP_TIMEOUT_EN
        check("drip_fault", int'(drip_fault), int'(m_fault));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit rst, input bit up, input bit dn, input bit ack);
        reset    = rst;
        btn_up   = up;
        btn_down = dn;
        drip_ack = ack;
        @(posedge clk_2);
        model_edge(rst, up, dn, ack);
        #1;
        check_all();
    endtask

    task automatic wstep(input bit up, input bit dn, input bit ack);
        step(1'b0, up, dn, ack);
        if (int'(actual) != last_act) begin
            if (exp_q.size() == 0) check("unplanned_step", int'(actual), last_act);
            else check("step_value", int'(actual), int'(exp_q.pop_front()));
            check("actuator_during_step", int'(last_drive), 1);
        end
        last_act   = int'(actual);
        last_drive = heat_on | cool_on;
    endtask

    task automatic pulse(input bit up, input bit dn);
        wstep(up, dn, 1'b0);
        wstep(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_state(input int target, input int budget, output int cycles);
        cycles = 0;
        while (int'(state_o) != target && cycles < budget) begin
            wstep(1'b0, 1'b0, 1'b0);
            cycles++;
        end
        check("reach_state", int'(state_o), target);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_desired", int'(desired), 0);
        check("rst_actual", int'(actual), 0);
        check("rst_cool_on", int'(cool_on), 0);
        check("rst_heat_on", int'(heat_on), 0);
        check("rst_drip_req", int'(drip_req), 0);
        check("rst_state", int'(state_o), S_IDLE);
        exp_q.delete();
        last_act   = 0;
        last_drive = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;

        tbl[0]  = mk(1, 0, 1); tbl[1]  = mk(1, 0, 2); tbl[2]  = mk(1, 0, 3);
        tbl[3]  = mk(1, 0, 4); tbl[4]  = mk(1, 0, 5); tbl[5]  = mk(1, 0, 6);
        tbl[6]  = mk(1, 0, 7); tbl[7]  = mk(1, 0, 7); tbl[8]  = mk(1, 0, 7);
        tbl[9]  = mk(0, 1, 6); tbl[10] = mk(0, 1, 5); tbl[11] = mk(1, 1, 5);
        tbl[12] = mk(0, 1, 4); tbl[13] = mk(0, 1, 3); tbl[14] = mk(0, 1, 2);
        tbl[15] = mk(0, 1, 1); tbl[16] = mk(0, 1, 0); tbl[17] = mk(0, 1, 0);

        do_reset();
        do_reset();

        // Heat run to setpoint 3, then minimum off-time, then idle.
        exp_q = '{3'd1, 3'd2, 3'd3};
        repeat (3) pulse(1'b1, 1'b0);
        wait_state(S_HOLD, 40, n);
        check("hold_entry_actual", int'(actual), 3);
        wait_state(S_IDLE, 40, n);
        check("hold_cycles", n, P_MO * P_TD);
        check("idle_heat_off", int'(heat_on), 0);
        check("heat_queue_drained", exp_q.size(), 0);

        // Setpoint saturation and cancellation table.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].up, tbl[i].dn, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("table_desired_%0d", i), int'(desired), tbl[i].exp_des);
        end

        // Cool from 5 toward 0: third cumulative step forces DRAIN.
        do_reset();
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        repeat (5) pulse(1'b1, 1'b0);
        wait_state(S_HOLD, 40, n);
        wait_state(S_IDLE, 40, n);
        exp_q = '{3'd4, 3'd3, 3'd2};
        repeat (5) pulse(1'b0, 1'b1);
        wait_state(S_DRAIN, 80, n);
        check("drain_actual", int'(actual), 2);
        check("drain_req", int'(drip_req), 1);
        check("drain_cool_off", int'(cool_on), 0);
`ifdef AC_DRIP_TIMEOUT_EN
        repeat (2 * P_TO + 2) wstep(1'b0, 1'b0, 1'b0);
        check("timeout_fault", int'(drip_fault), 1);
        check("timeout_req_held", int'(drip_req), 1);
`else
        repeat (3) wstep(1'b0, 1'b0, 1'b0);
`endif
        check("drain_waits", int'(state_o), S_DRAIN);
        wstep(1'b0, 1'b0, 1'b1);
        check("ack_to_hold", int'(state_o), S_HOLD);
        check("ack_req_drop", int'(drip_req), 0);
`ifdef AC_DRIP_TIMEOUT_EN
        check("fault_sticky", int'(drip_fault), 1);
`endif
        exp_q = '{3'd1, 3'd0};
        wait_state(S_IDLE, 40, n);
        wait_state(S_COOL, 40, n);
        wait_state(S_HOLD, 40, n);
        check("cool_resume_actual", int'(actual), 0);
        check("cool_queue_drained", exp_q.size(), 0);

        // One more cool step reaches the limit again; reset aborts DRAIN.
        wait_state(S_IDLE, 40, n);
        exp_q = '{3'd1};
        pulse(1'b1, 1'b0);
        wait_state(S_HOLD, 40, n);
        wait_state(S_IDLE, 40, n);
        exp_q = '{3'd0};
        pulse(1'b0, 1'b1);
        wait_state(S_DRAIN, 40, n);
        check("second_drain_req", int'(drip_req), 1);
        do_reset();

        // Setpoint drops to actual mid-HEAT: HOLD with no step, then cool.
        do_reset();
        exp_q = '{3'd1, 3'd2};
        repeat (3) pulse(1'b1, 1'b0);
        check("heat_mid_actual", int'(actual), 2);
        check("heat_mid_state", int'(state_o), S_HEAT);
        pulse(1'b0, 1'b1);
        check("reverse_hold", int'(state_o), S_HOLD);
        check("reverse_no_step", int'(actual), 2);
        exp_q = '{3'd1};
        pulse(1'b0, 1'b1);
        wait_state(S_IDLE, 40, n);
        wait_state(S_COOL, 40, n);
        wait_state(S_HOLD, 40, n);
        check("reverse_cool_actual", int'(actual), 1);

        // Randomized buttons, acks and occasional resets against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 249) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
